// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared execute-stage opcodes (MUL_*, DIV_*) and divider FSM state.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam logic [3:0] MUL_MUL    = 4'h0;
    localparam logic [3:0] MUL_MULH   = 4'h1;
    localparam logic [3:0] MUL_MULHSU = 4'h2;
    localparam logic [3:0] MUL_MULHU  = 4'h3;
    localparam logic [3:0] DIV_DIV    = 4'h4;
    localparam logic [3:0] DIV_DIVU   = 4'h5;
    localparam logic [3:0] DIV_REM    = 4'h6;
    localparam logic [3:0] DIV_REMU   = 4'h7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } div_state_t;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == DIV_DIV) || (op == DIV_DIVU) || (op == DIV_REM) || (op == DIV_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational radix-2 restoring division step on {rem,quo}.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_dvs,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // Partial remainder stays below the divisor, so XLEN+1 bits hold the trial.
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, i_dvs};
    assign o_rem   = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign o_quo   = {i_quo[XLEN-2:0], ~w_diff[XLEN]};

endmodule
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
// Module   : div
// Purpose  : Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//            Define DIV_EARLY_OUT_EN to skip iteration when |a| < |b|.
// Revision : 1.0 - initial release
// ============================================================================
module div
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      div_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            unknown_op
);

    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(XLEN - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic             busy_q, busy_d, done_q, done_d, unk_q, unk_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic             w_signed;
    logic [XLEN-1:0]  w_a_mag, w_b_mag;
    logic [XLEN-1:0]  w_rem_step, w_quo_step, w_quo_fix, w_rem_fix;

    assign w_signed  = (div_op == DIV_DIV) || (div_op == DIV_REM);
    assign w_a_mag   = (w_signed && a[XLEN-1]) ? -a : a;
    assign w_b_mag   = (w_signed && b[XLEN-1]) ? -b : b;
    assign w_quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign w_rem_fix = neg_rem_q ? -rem_q : rem_q;

    div_step #(.XLEN(XLEN)) u_step (
        .i_rem (rem_q),
        .i_quo (quo_q),
        .i_dvs (dvs_q),
        .o_rem (w_rem_step),
        .o_quo (w_quo_step)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unk_d     = unk_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = div_op;
                    busy_d    = 1'b1;
                    unk_d     = 1'b0;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = w_a_mag;
                    dvs_d     = w_b_mag;
                    neg_quo_d = w_signed && (a[XLEN-1] ^ b[XLEN-1]);
                    neg_rem_d = w_signed && a[XLEN-1];
                    state_d   = CALC;
                    // Special cases preload the unsigned result and skip iteration.
                    if (!is_div_op(div_op)) begin
                        quo_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = FIN;
                    end else if (b == '0) begin
                        quo_d     = '1;
                        rem_d     = a;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = FIN;
                    end else if (w_signed && (a == INT_MIN) && (b == '1)) begin
                        quo_d     = INT_MIN;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = FIN;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (w_a_mag < w_b_mag) begin
                        quo_d   = '0;
                        rem_d   = w_a_mag;
                        state_d = FIN;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = w_rem_step;
                quo_d = w_quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                unk_d   = !is_div_op(op_q);
                state_d = IDLE;
                if (!is_div_op(op_q)) begin
                    result_d = '0;
                end else if ((op_q == DIV_REM) || (op_q == DIV_REMU)) begin
                    result_d = w_rem_fix;
                end else begin
                    result_d = w_quo_fix;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            unk_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            unk_q     <= unk_d;
            result_q  <= result_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign unknown_op = unk_q;

endmodule
`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_div
// Purpose  : Directed and random self-checking bench for the div block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  div_op = 4'h0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, unknown_op;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] res;
        logic        unk;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    div #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .div_op     (div_op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .unknown_op (unknown_op)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mag(input logic [3:0] op, input logic [31:0] x);
        if ((op == DIV_DIV || op == DIV_REM) && x[31]) return 32'(-$signed(x));
        return x;
    endfunction

    // Reference result per RISC-V M semantics using native arithmetic.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic ovf;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (op)
            DIV_DIV:  return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
            DIV_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            DIV_REM:  return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
            DIV_REMU: return (y == 0) ? x : x % y;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        if (!(op == DIV_DIV || op == DIV_DIVU || op == DIV_REM || op == DIV_REMU)) return 2;
        if (y == 0) return 2;
        if ((op == DIV_DIV || op == DIV_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
`ifdef DIV_EARLY_OUT_EN
        if (mag(op, x) < mag(op, y)) return 2;
`endif
        return 34;
    endfunction

    // Issue one op in the current cycle, then wait for done and check it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_res,
                          input logic exp_unk, input int poke_at);
        int   n;
        bit   seen;
        bit   busy_ok;
        exp_t e;
        exp_q.push_back('{exp_res, exp_unk, lat_of(op, av, bv)});
        start = 1'b1; div_op = op; a = av; b = bv;
        n = 0; seen = 0; busy_ok = 1;
        while (!seen && n < 100) begin
            @(posedge clk); #1; n++;
            if (n == 1) begin
                start = 1'b0; div_op = 4'($urandom); a = $urandom; b = $urandom;
            end
            if (n == poke_at) begin
                start = 1'b1; div_op = DIV_DIVU; a = 32'd1; b = 32'd1;
            end
            if (n == poke_at + 1) start = 1'b0;
            if (done) seen = 1;
            else if (busy !== 1'b1) busy_ok = 0;
        end
        e = exp_q.pop_front();
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(n), 32'(e.lat));
        chk({tag, " busy_high"}, 32'(busy_ok), 32'd1);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, " result"}, result, e.res);
        chk({tag, " unknown_op"}, 32'(unknown_op), 32'(e.unk));
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk({tag, " no_done"}, 32'(cnt), 32'd0);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset unknown_op", 32'(unknown_op), 32'd0);

        run_op("divu_100_7", DIV_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 0);
        run_op("remu_100_7", DIV_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 0);
        run_op("div_m7_2", DIV_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("rem_m7_2", DIV_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("rem_7_m2", DIV_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 0);
        run_op("div_5_0", DIV_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("remu_5_0", DIV_REMU, 32'd5, 32'd0, 32'd5, 1'b0, 0);
        run_op("div_ovf", DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
        run_op("rem_ovf", DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        run_op("unknown", 4'hF, 32'd9, 32'd3, 32'd0, 1'b1, 0);
        run_op("divu_9_3", DIV_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 0);
        run_op("divu_3_10", DIV_DIVU, 32'd3, 32'd10, 32'd0, 1'b0, 0);
        run_op("div_min_3", DIV_DIV, 32'h8000_0000, 32'd3, 32'hD555_5556, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            rop = 4'(DIV_DIV + 4'($urandom_range(0, 3)));
            ra  = $urandom;
            rb  = (i % 2 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (i == 5) rb = 32'hFFFF_FFF0;
            run_op("random", rop, ra, rb, model(rop, ra, rb), 1'b0, 0);
        end

        run_op("start_while_busy", DIV_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 5);
        idle_check("after_busy_start", 40);

        start = 1'b1; div_op = DIV_DIVU; a = 32'd1000; b = 32'd3;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset result", result, 32'd0);
        idle_check("midreset", 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
